// File: rtl/mac_sequencer.sv
// ---------------------------------------------------------------------------
// mac_sequencer
//
// Sequential multiply-accumulate controller for a single neuron. Streams
// N_INPUTS unsigned 4-bit activation/weight pairs through one shared external
// 4x4 multiplier and sums the 8-bit products into an ACC_WIDTH accumulator.
//
// Parameters:
//   N_INPUTS   pairs per accumulation (>= 1)
//   ACC_WIDTH  accumulator / result width (>= 8)
//   CNT_WIDTH  pair-counter width, 2**CNT_WIDTH > N_INPUTS
//
// Optional feature macro:
//   SATURATE_EN  defined   -> accumulator clamps at all-ones on overflow
//                undefined -> accumulator wraps modulo 2**ACC_WIDTH
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   begin an accumulation (honoured only in IDLE)
//   busy          out  high in every state except IDLE
//   x_data        in   [3:0] activation
//   w_data        in   [3:0] weight
//   in_valid      in   x_data/w_data pair valid
//   in_ready      out  pair accepted this cycle when in_valid is high
//   mul_a         out  [3:0] registered multiplier operand (activation)
//   mul_b         out  [3:0] registered multiplier operand (weight)
//   mul_out       in   [7:0] combinational product mul_a * mul_b
//   result        out  [ACC_WIDTH-1:0] final sum, held between runs
//   result_valid  out  one-cycle pulse when result is new
// ---------------------------------------------------------------------------
module mac_sequencer #(
  parameter int N_INPUTS  = 4,
  parameter int ACC_WIDTH = 10,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  input  logic [3:0]           x_data,
  input  logic [3:0]           w_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [3:0]           mul_a,
  output logic [3:0]           mul_b,
  input  logic [7:0]           mul_out,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 result_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(N_INPUTS - 1);

  state_t                 state;
  state_t                 next_state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   acc_sum;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic                   prod_vld;
  logic                   accept;
  logic                   last_pair;
  logic                   start_ok;

  assign accept    = in_valid && in_ready;
  assign last_pair = accept && (cnt == LAST_IDX);
  assign start_ok  = (state == IDLE) && start;

  // The multiplier output belongs to the operands registered on the
  // previous accept, so it is only folded in while prod_vld is set.
`ifdef SATURATE_EN
  logic [ACC_WIDTH:0] raw_sum;

  always_comb begin
    raw_sum = {1'b0, acc} + (ACC_WIDTH + 1)'(mul_out);
    acc_sum = raw_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : raw_sum[ACC_WIDTH-1:0];
  end
`else
  always_comb begin
    acc_sum = acc + ACC_WIDTH'(mul_out);
  end
`endif

  assign acc_next = prod_vld ? acc_sum : acc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (last_pair) next_state = DRAIN;
      DRAIN:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode, purely from state
  always_comb begin
    busy         = 1'b0;
    in_ready     = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
      end
      ACCUM: begin
        busy     = 1'b1;
        in_ready = 1'b1;
      end
      DRAIN: begin
        busy = 1'b1;
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Operand registers, pair counter and accumulator. Operands are not
  // cleared on start; they simply hold until the next accepted pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a    <= 4'd0;
      mul_b    <= 4'd0;
      cnt      <= '0;
      acc      <= '0;
      prod_vld <= 1'b0;
    end else if (start_ok) begin
      cnt      <= '0;
      acc      <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= accept;
      acc      <= acc_next;
      if (accept) begin
        mul_a <= x_data;
        mul_b <= w_data;
        cnt   <= cnt + CNT_WIDTH'(1);
      end
    end
  end

  // The last product is still pending in DRAIN, so result captures the
  // sum including it on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (state == DRAIN) begin
      result <= acc_next;
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mac_sequencer
//
// Directed bench for mac_sequencer. Three instances share clock, reset and
// the pair inputs but have separate start lines:
//   dut0  defaults (N_INPUTS=4, ACC_WIDTH=10)
//   dut1  N_INPUTS=2, ACC_WIDTH=8 (wrap / saturate behaviour)
//   dut2  N_INPUTS=1 (minimum length, immediate restart)
// The external multiplier is modelled by the bench for each instance.
// ---------------------------------------------------------------------------
module tb_mac_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] x_data;
  logic [3:0] w_data;
  logic       in_valid;

  logic       start0, start1, start2;
  logic       busy0, busy1, busy2;
  logic       in_ready0, in_ready1, in_ready2;
  logic [3:0] mul_a0, mul_a1, mul_a2;
  logic [3:0] mul_b0, mul_b1, mul_b2;
  logic [7:0] mul_out0, mul_out1, mul_out2;
  logic [9:0] result0;
  logic [7:0] result1;
  logic [9:0] result2;
  logic       result_valid0, result_valid1, result_valid2;

  int total;
  int bad;

  logic [3:0] xs [4];
  logic [3:0] ws [4];

`ifdef SATURATE_EN
  localparam logic [7:0] EXP_SMALL = 8'd255;
`else
  localparam logic [7:0] EXP_SMALL = 8'd194;
`endif

  assign mul_out0 = {4'd0, mul_a0} * {4'd0, mul_b0};
  assign mul_out1 = {4'd0, mul_a1} * {4'd0, mul_b1};
  assign mul_out2 = {4'd0, mul_a2} * {4'd0, mul_b2};

  mac_sequencer dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0),
    .x_data(x_data), .w_data(w_data), .in_valid(in_valid),
    .in_ready(in_ready0), .mul_a(mul_a0), .mul_b(mul_b0),
    .mul_out(mul_out0), .result(result0), .result_valid(result_valid0)
  );

  mac_sequencer #(.N_INPUTS(2), .ACC_WIDTH(8), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1),
    .x_data(x_data), .w_data(w_data), .in_valid(in_valid),
    .in_ready(in_ready1), .mul_a(mul_a1), .mul_b(mul_b1),
    .mul_out(mul_out1), .result(result1), .result_valid(result_valid1)
  );

  mac_sequencer #(.N_INPUTS(1), .ACC_WIDTH(10), .CNT_WIDTH(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2),
    .x_data(x_data), .w_data(w_data), .in_valid(in_valid),
    .in_ready(in_ready2), .mul_a(mul_a2), .mul_b(mul_b2),
    .mul_out(mul_out2), .result(result2), .result_valid(result_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; outputs are then settled
  // for the new cycle and inputs for that cycle are driven afterwards.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    total = total + 1;
    if (busy0 !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL reset_busy: got %b want 0", busy0); end
    total = total + 1;
    if (in_ready0 !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready0); end
    total = total + 1;
    if (mul_a0 !== 4'd0 || mul_b0 !== 4'd0) begin bad = bad + 1; $display("[TB] FAIL reset_operands: got a=%0d b=%0d want 0 0", mul_a0, mul_b0); end
    total = total + 1;
    if (result0 !== 10'd0) begin bad = bad + 1; $display("[TB] FAIL reset_result: got %0d want 0", result0); end
    total = total + 1;
    if (result_valid0 !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL reset_result_valid: got %b want 0", result_valid0); end
    total = total + 1;
    if (dut0.acc !== 10'd0) begin bad = bad + 1; $display("[TB] FAIL reset_acc: got %0d want 0", dut0.acc); end
    rst = 1'b0;
    step;
  endtask

  task automatic test_back_to_back;
    start0 = 1'b1;
    in_valid = 1'b0;
    total = total + 1;
    if (busy0 !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL b2b_idle_busy: got %b want 0", busy0); end
    step;
    start0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total = total + 1;
      if (in_ready0 !== 1'b1) begin bad = bad + 1; $display("[TB] FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready0); end
      total = total + 1;
      if (result_valid0 !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL b2b_early_valid[%0d]: got %b want 0", i, result_valid0); end
      in_valid = 1'b1;
      x_data = xs[i];
      w_data = ws[i];
      step;
    end
    in_valid = 1'b0;
    total = total + 1;
    if (in_ready0 !== 1'b0 || busy0 !== 1'b1) begin bad = bad + 1; $display("[TB] FAIL b2b_drain: got in_ready=%b busy=%b want 0 1", in_ready0, busy0); end
    total = total + 1;
    if (result_valid0 !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL b2b_drain_valid: got %b want 0", result_valid0); end
    step;
    total = total + 1;
    if (result_valid0 !== 1'b1) begin bad = bad + 1; $display("[TB] FAIL b2b_valid_cycle6: got %b want 1", result_valid0); end
    total = total + 1;
    if (result0 !== 10'd232) begin bad = bad + 1; $display("[TB] FAIL b2b_result: got %0d want 232", result0); end
    step;
    total = total + 1;
    if (result_valid0 !== 1'b0 || busy0 !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL b2b_after: got valid=%b busy=%b want 0 0", result_valid0, busy0); end
    total = total + 1;
    if (result0 !== 10'd232) begin bad = bad + 1; $display("[TB] FAIL b2b_result_held: got %0d want 232", result0); end
  endtask

  task automatic test_gaps;
    int sum_prev;
    int sum_cur;
    sum_cur = 0;
    start0 = 1'b1;
    step;
    start0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      x_data = xs[i];
      w_data = ws[i];
      step;
      sum_prev = sum_cur;
      sum_cur = sum_cur + int'(xs[i]) * int'(ws[i]);
      in_valid = 1'b0;
      x_data = 4'hA;
      w_data = 4'h5;
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          total = total + 1;
          if (mul_a0 !== xs[i] || mul_b0 !== ws[i]) begin bad = bad + 1; $display("[TB] FAIL gap_operands[%0d.%0d]: got a=%0d b=%0d want %0d %0d", i, g, mul_a0, mul_b0, xs[i], ws[i]); end
          total = total + 1;
          if (in_ready0 !== 1'b1) begin bad = bad + 1; $display("[TB] FAIL gap_in_ready[%0d.%0d]: got %b want 1", i, g, in_ready0); end
          total = total + 1;
          if (g == 0 && dut0.acc !== 10'(sum_prev)) begin bad = bad + 1; $display("[TB] FAIL gap_acc_pending[%0d]: got %0d want %0d", i, dut0.acc, sum_prev); end
          else if (g == 1 && dut0.acc !== 10'(sum_cur)) begin bad = bad + 1; $display("[TB] FAIL gap_acc_idle[%0d]: got %0d want %0d", i, dut0.acc, sum_cur); end
          step;
        end
      end
    end
    total = total + 1;
    if (in_ready0 !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL gap_drain_in_ready: got %b want 0", in_ready0); end
    step;
    total = total + 1;
    if (result_valid0 !== 1'b1) begin bad = bad + 1; $display("[TB] FAIL gap_valid: got %b want 1", result_valid0); end
    total = total + 1;
    if (result0 !== 10'd232) begin bad = bad + 1; $display("[TB] FAIL gap_result: got %0d want 232", result0); end
    step;
  endtask

  task automatic test_start_ignored;
    int pulses;
    pulses = 0;
    start0 = 1'b1;
    step;
    start0 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (result_valid0 === 1'b1) pulses = pulses + 1;
      if (c == 6) begin
        total = total + 1;
        if (result_valid0 !== 1'b1 || result0 !== 10'd232) begin bad = bad + 1; $display("[TB] FAIL restart_result: got valid=%b result=%0d want 1 232", result_valid0, result0); end
      end
      if (c <= 4) begin
        in_valid = 1'b1;
        x_data = xs[c-1];
        w_data = ws[c-1];
      end else begin
        in_valid = 1'b0;
      end
      start0 = (c == 2);
      step;
    end
    start0 = 1'b0;
    total = total + 1;
    if (pulses !== 1) begin bad = bad + 1; $display("[TB] FAIL restart_pulses: got %0d want 1", pulses); end
    total = total + 1;
    if (busy0 !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL restart_idle_busy: got %b want 0", busy0); end
  endtask

  task automatic test_reset_mid;
    start0 = 1'b1;
    step;
    start0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      x_data = xs[i];
      w_data = ws[i];
      step;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    total = total + 1;
    if (busy0 !== 1'b0 || in_ready0 !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL midrst_ctrl: got busy=%b in_ready=%b want 0 0", busy0, in_ready0); end
    total = total + 1;
    if (result0 !== 10'd0) begin bad = bad + 1; $display("[TB] FAIL midrst_result: got %0d want 0", result0); end
    step;
    start0 = 1'b1;
    step;
    start0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      x_data = 4'd3;
      w_data = 4'd3;
      step;
    end
    in_valid = 1'b0;
    step;
    total = total + 1;
    if (result_valid0 !== 1'b1) begin bad = bad + 1; $display("[TB] FAIL midrst_rerun_valid: got %b want 1", result_valid0); end
    total = total + 1;
    if (result0 !== 10'd36) begin bad = bad + 1; $display("[TB] FAIL midrst_rerun_result: got %0d want 36", result0); end
    step;
  endtask

  task automatic test_saturate;
    start1 = 1'b1;
    step;
    start1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      x_data = 4'd15;
      w_data = 4'd15;
      step;
    end
    in_valid = 1'b0;
    total = total + 1;
    if (in_ready1 !== 1'b0 || busy1 !== 1'b1) begin bad = bad + 1; $display("[TB] FAIL small_drain: got in_ready=%b busy=%b want 0 1", in_ready1, busy1); end
    step;
    total = total + 1;
    if (result_valid1 !== 1'b1) begin bad = bad + 1; $display("[TB] FAIL small_valid: got %b want 1", result_valid1); end
    total = total + 1;
    if (result1 !== EXP_SMALL) begin bad = bad + 1; $display("[TB] FAIL small_result: got %0d want %0d", result1, EXP_SMALL); end
    step;
    total = total + 1;
    if (result_valid1 !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL small_valid_end: got %b want 0", result_valid1); end
  endtask

  task automatic test_single;
    start2 = 1'b1;
    step;
    start2 = 1'b0;
    in_valid = 1'b1;
    x_data = 4'd7;
    w_data = 4'd5;
    total = total + 1;
    if (in_ready2 !== 1'b1) begin bad = bad + 1; $display("[TB] FAIL single_in_ready: got %b want 1", in_ready2); end
    step;
    in_valid = 1'b0;
    total = total + 1;
    if (in_ready2 !== 1'b0 || result_valid2 !== 1'b0) begin bad = bad + 1; $display("[TB] FAIL single_drain: got in_ready=%b valid=%b want 0 0", in_ready2, result_valid2); end
    step;
    total = total + 1;
    if (result_valid2 !== 1'b1 || result2 !== 10'd35) begin bad = bad + 1; $display("[TB] FAIL single_result: got valid=%b result=%0d want 1 35", result_valid2, result2); end
    step;
    total = total + 1;
    if (busy2 !== 1'b0 || result2 !== 10'd35) begin bad = bad + 1; $display("[TB] FAIL single_idle: got busy=%b result=%0d want 0 35", busy2, result2); end
    start2 = 1'b1;
    step;
    start2 = 1'b0;
    in_valid = 1'b1;
    x_data = 4'd4;
    w_data = 4'd4;
    step;
    in_valid = 1'b0;
    step;
    total = total + 1;
    if (result_valid2 !== 1'b1 || result2 !== 10'd16) begin bad = bad + 1; $display("[TB] FAIL single_restart: got valid=%b result=%0d want 1 16", result_valid2, result2); end
    step;
  endtask

  initial begin
    total = 0;
    bad = 0;
    xs[0] = 4'd1;  ws[0] = 4'd1;
    xs[1] = 4'd2;  ws[1] = 4'd3;
    xs[2] = 4'd15; ws[2] = 4'd15;
    xs[3] = 4'd0;  ws[3] = 4'd9;
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    in_valid = 1'b0;
    x_data = 4'd0;
    w_data = 4'd0;

    test_reset;
    test_back_to_back;
    test_gaps;
    test_start_ignored;
    test_reset_mid;
    test_saturate;
    test_single;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Sequential multiply-accumulate controller for one neuron. It streams N_INPUTS unsigned 4-bit input/weight pairs through one shared external 4-bit×4-bit multiplier and accumulates the 8-bit products into a wider sum. It sits between the layer-level input/weight buffers and the neuron activation stage. It owns the multiplier's operand registers, the accumulator, the pair counter and the start/result handshake.

## Interface
- N_INPUTS, default 4: number of pairs per accumulation; ≥1.
- ACC_WIDTH, default 10: accumulator and result width; ≥8.
- CNT_WIDTH, default 3: pair-counter width; must satisfy 2^CNT_WIDTH > N_INPUTS.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin an accumulation; honoured only in IDLE.
- busy  output  1  high in every state except IDLE.
- x_data  input  4  unsigned input activation.
- w_data  input  4  unsigned weight.
- in_valid  input  1  x_data/w_data pair is valid.
- in_ready  output  1  sequencer accepts a pair this cycle.
- mul_a  output  4  registered operand A to the multiplier (x).
- mul_b  output  4  registered operand B to the multiplier (w).
- mul_out  input  8  combinational product of mul_a × mul_b.
- result  output  ACC_WIDTH  final sum; held until the next start is accepted.
- result_valid  output  1  one-cycle pulse, result is new.

## Operation
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - busy=0, in_ready=0.
  - start=1 → ACCUM; accumulator, counter and prod_vld cleared at the same edge.
- ACCUM:
  - in_ready=1.
  - Accept when in_valid && in_ready: x_data→mul_a, w_data→mul_b, prod_vld←1, counter+1.
  - Cycle without accept: prod_vld←0; mul_a/mul_b hold their values.
  - Every edge with prod_vld=1: acc ← acc + zero-extended mul_out.
  - Accept of the N_INPUTS-th pair → DRAIN; in_ready is 0 from the next cycle.
- DRAIN:
  - in_ready=0.
  - Final product is added at the edge leaving DRAIN; → DONE.
- DONE:
  - result_valid=1 for exactly this cycle; result = final acc; → IDLE.
- Arithmetic is unsigned. Default sum wraps modulo 2^ACC_WIDTH; the default parameters (max 4×225=900) never overflow.
- start in any state other than IDLE is ignored; the current accumulation is not restarted.
- in_valid while in_ready=0 is ignored; the pair is not consumed.
- rst at any cycle, including mid-ACCUM: state→IDLE and the partial sum is discarded.

## Timing
- Reset values: busy=0, in_ready=0, mul_a=0, mul_b=0, result=0, result_valid=0, acc=0, counter=0, prod_vld=0.
- in_ready is high from the cycle after start is accepted.
- Product of a pair accepted in cycle k is in acc after the edge ending cycle k+1.
- result_valid asserts in the 2nd cycle after the cycle the last pair is accepted.
- With in_valid held high, result_valid asserts N_INPUTS+2 cycles after the start cycle (6 for defaults).
- start may be asserted in the cycle after DONE (IDLE). Minimum spacing between start cycles is N_INPUTS+3.
- result updates at the edge entering DONE and is stable through IDLE.

## Configuration
- SATURATE_EN defined:
  - Accumulation saturates: if acc + mul_out exceeds 2^ACC_WIDTH−1, acc ← all-ones and stays there until the next start.
- SATURATE_EN undefined:
  - Plain modulo-2^ACC_WIDTH wrap, no extra comparator logic.

## Test plan
- Defaults, start then pairs (1,1),(2,3),(15,15),(0,9) back-to-back → result=232, result_valid high exactly 6 cycles after start, in_ready low from the DRAIN cycle.
- Same pairs with in_valid deasserted for 2 cycles between each pair → result=232; mul_a/mul_b unchanged during the gaps; accumulator unchanged in idle cycles.
- start pulsed again during ACCUM → ignored; result=232, only one result_valid pulse.
- rst asserted after the 2nd accepted pair → next cycle busy=0, in_ready=0, result=0. A new run of (3,3)×4 → result=36.
- ACC_WIDTH=8, N_INPUTS=2, pairs (15,15),(15,15): without SATURATE_EN → result=194; with SATURATE_EN → result=255.
- N_INPUTS=1, pair (7,5) → result=35, result_valid 3 cycles after start. Immediate restart in the following IDLE cycle with (4,4) → result=16.
